jpeg_mcu_enc: RTL and testbench
===============================

Name: jpeg_mcu_enc

Overview:
- Entropy-encoder counterpart of the MCU coefficient decoder.
- Accepts one 8x8 block of quantised coefficients in zigzag order (idx 0..63). Performs DC differential prediction per component and AC zero-run/ZRL/EOB coding.
- Queries an external Huffman code table with {table, symbol}.
- Emits variable-width fields (Huffman code concatenated with amplitude bits) to a downstream bit packer using a v_o/yumi_i handshake.

Parameters:
- COEF_W, 16, coefficient/DC-predictor width (two's complement)
- MAX_SIZE, 11, maximum magnitude category supported

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- img_start_i  in  1  start of image: clears predictors and FSM
- restart_i  in  1  restart-interval boundary: clears DC predictors
- inport_v_i  in  1  coefficient valid
- inport_ready_o  out  1  encoder can accept a coefficient
- inport_data_i  in  16  quantised coefficient
- inport_idx_i  in  6  zigzag index
- inport_type_i  in  2  0=Y, 1=Cb, 2=Cr; sampled at idx 0
- lookup_req_o  out  1  Huffman table request
- lookup_table_o  out  2  0=Y DC, 1=Y AC, 2=Cx DC, 3=Cx AC
- lookup_symbol_o  out  8  DC: size; AC: {run[3:0], size[3:0]}
- lookup_valid_i  in  1  lookup result valid
- lookup_code_i  in  16  Huffman code, right-aligned
- lookup_width_i  in  5  code length, 1..16
- v_o  out  1  output field valid
- yumi_i  in  1  downstream consumes field this cycle
- outport_bits_o  out  32  {code, amplitude}, right-aligned
- outport_width_o  out  6  valid bits in outport_bits_o (1..27)
- outport_last_o  out  1  final field of block

Behaviour:
- Reset: all outputs 0, FSM in S_IN, predictors/run/ZRL counters 0, coef counter 0. inport_ready_o rises the first cycle after reset release.
- FSM states: S_IN, S_LOOKUP, S_OUT.
- S_IN:
  - inport_ready_o=1; a transfer occurs when inport_v_i & inport_ready_o.
  - idx 0: capture type. diff = data - prev_dc[type], COEF_W wrap. Set prev_dc[type]=data. Symbol=size(diff) -> S_LOOKUP.
  - AC zero, idx<63: run++, stay in S_IN. Throughput 1 coefficient/cycle.
  - AC nonzero: zrl_cnt=run>>4, symbol={run[3:0],size}, run cleared -> S_LOOKUP.
  - AC zero at idx 63: pending run discarded, symbol 0x00 (EOB) -> S_LOOKUP.
- size(v): bit length of |v|; 0 for v=0. Inputs beyond MAX_SIZE are illegal.
- Amplitude: low size bits of v if v≥0, of v-1 if v<0. size 0 contributes no bits.
- S_LOOKUP:
  - lookup_req_o=1, held with table and symbol stable until lookup_valid_i (same-cycle valid allowed).
  - ZRL (0xF0) fields are issued first, one per lookup, while zrl_cnt>0; then the pending symbol.
  - On valid: register bits={code,amp}, width=code_w+size (ZRL/EOB: code_w only) -> S_OUT.
- S_OUT:
  - v_o=1; bits, width and last held stable until yumi_i.
  - On yumi_i: if more ZRL or the pending symbol remain -> S_LOOKUP; else -> S_IN.
- outport_last_o=1 on the EOB field, or on the idx-63 symbol when coefficient 63 is nonzero (no EOB then).
- Table selection: DC table for idx 0, AC table otherwise; Y vs Cx from the captured type.
- Latency: idx-0 accept at cycle N -> lookup_req_o at N+1 -> v_o at the cycle after lookup_valid_i.
- Backpressure: yumi_i low holds S_OUT indefinitely and inport_ready_o stays 0.
- img_start_i (any state, highest priority): next cycle FSM=S_IN, v_o=0, lookup_req_o=0, counters and all predictors 0. The in-flight block is abandoned.
- restart_i: clears predictors only. Intended at a block boundary; if asserted mid-block, the current block's diff is unaffected.
- img_start_i and restart_i in the same cycle: img_start_i behaviour applies.

Optional Feature:
- Macro: JPEG_MCU_ENC_IDX_CHECK_EN.
- Defined:
  - Adds output error_o (1 bit, reset 0).
  - An accepted coefficient whose inport_idx_i differs from the internal counter sets error_o sticky.
  - The coefficient is still processed using the internal counter.
  - error_o is cleared only by img_start_i or reset.
- Undefined: inport_idx_i is ignored; the internal counter alone defines position; no error_o port.

Test Plan:
- Y block, DC=+5, 63 zero ACs, table returns code 0b100/w3 for sym 0x03 -> field bits=0b100101 width 6; then table 1 sym 0x00 -> EOB field, last=1.
- Next Y block, DC=3 -> diff -2, sym 0x02, amp 0b01. Then Cb block DC=-1 -> table 2, sym 0x01, amp 0b0 (independent predictor).
- AC idx1..20 zero, idx21=7, rest zero -> ZRL field (table 1, sym 0xF0), then sym 0x43 amp 0b111, then EOB last=1.
- idx63=-1, all other ACs zero -> run 62 gives three ZRLs, then sym 0xE1 amp 0b0 last=1; no EOB.
- yumi_i low 5 cycles in S_OUT -> v_o, bits, width stable, inport_ready_o=0; then img_start_i mid-block -> v_o=0 next cycle, next DC=4 gives diff 4.
- With JPEG_MCU_ENC_IDX_CHECK_EN: send idx 5 in place of 3 -> error_o=1 and stays 1 until img_start_i.

Source files
------------

// File: rtl/jpeg_mcu_enc.sv
// JPEG baseline entropy encoder: one 8x8 zigzag block -> DC/AC Huffman+amplitude fields.
// Optional JPEG_MCU_ENC_IDX_CHECK_EN adds a sticky error_o for idx/counter mismatches.
module jpeg_mcu_enc #(
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned MAX_SIZE = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              img_start_i,
    input  logic              restart_i,
    input  logic              inport_v_i,
    output logic              inport_ready_o,
    input  logic [COEF_W-1:0] inport_data_i,
    input  logic [5:0]        inport_idx_i,
    input  logic [1:0]        inport_type_i,
    output logic              lookup_req_o,
    output logic [1:0]        lookup_table_o,
    output logic [7:0]        lookup_symbol_o,
    input  logic              lookup_valid_i,
    input  logic [15:0]       lookup_code_i,
    input  logic [4:0]        lookup_width_i,
    output logic              v_o,
    input  logic              yumi_i,
    output logic [31:0]       outport_bits_o,
    output logic [5:0]        outport_width_o,
    output logic              outport_last_o
`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
    ,
    output logic              error_o
`endif
);

    localparam int unsigned SIZE_W = 4;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned BITS_W = 32;
    localparam int unsigned OW_W   = 6;

    typedef enum logic [1:0] {S_IN, S_LOOKUP, S_OUT} state_t;

    state_t state_q, state_d;
    logic   ready_d, req_d, v_d;

    logic [IDX_W-1:0]  coef_cnt_q;
    logic [IDX_W-1:0]  run_q;
    logic [1:0]        zrl_q;
    logic              cx_q;
    logic [7:0]        pend_sym_q;
    logic [SIZE_W-1:0] pend_size_q;
    logic [COEF_W-1:0] pend_amp_q;
    logic              pend_last_q;
    logic              pend_sent_q;
    logic [COEF_W-1:0] prev_dc_q [4];

    // Magnitude category: bit length of |v|
    function automatic logic [SIZE_W-1:0] size_of(input logic [COEF_W-1:0] v);
        logic [COEF_W-1:0] mag;
        logic [SIZE_W-1:0] s;
        mag = v[COEF_W-1] ? COEF_W'(-v) : v;
        s   = '0;
        for (int unsigned i = 0; i < MAX_SIZE; i++) begin
            if (mag[i]) s = SIZE_W'(i + 1);
        end
        return s;
    endfunction

    // Amplitude bits: v for positive values, v-1 (ones' complement) for negative
    function automatic logic [COEF_W-1:0] amp_of(input logic [COEF_W-1:0] v,
                                                 input logic [SIZE_W-1:0] sz);
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] mask;
        a    = v[COEF_W-1] ? COEF_W'(v - COEF_W'(1)) : v;
        mask = COEF_W'((COEF_W'(1) << sz) - COEF_W'(1));
        return a & mask;
    endfunction

    logic              xfer, is_dc, is_end, coef_zero, in_go, issue_zrl;
    logic [COEF_W-1:0] prev_sel, diff, coef_val, coef_amp;
    logic [SIZE_W-1:0] coef_size;
    logic [1:0]        in_zrl;
    logic [7:0]        in_sym;
    logic [BITS_W-1:0] lk_bits;
    logic [OW_W-1:0]   lk_width;

    // Input-side symbol formation for the coefficient presented this cycle
    always_comb begin
        xfer      = inport_v_i & inport_ready_o;
        is_dc     = (coef_cnt_q == '0);
        is_end    = (coef_cnt_q == IDX_W'(63));
        coef_zero = (inport_data_i == '0);
        prev_sel  = restart_i ? '0 : prev_dc_q[inport_type_i];
        diff      = COEF_W'(inport_data_i - prev_sel);
        coef_val  = is_dc ? diff : inport_data_i;
        coef_size = size_of(coef_val);
        coef_amp  = amp_of(coef_val, coef_size);
        in_go     = xfer & (is_dc | ~coef_zero | is_end);
        in_zrl    = (is_dc | coef_zero) ? 2'd0 : run_q[5:4];
        if (is_dc)          in_sym = {4'h0, coef_size};
        else if (coef_zero) in_sym = 8'h00;
        else                in_sym = {run_q[3:0], coef_size};
    end

    // Lookup-result formatting: ZRL fields carry no amplitude
    always_comb begin
        issue_zrl = (zrl_q != 2'd0);
        if (issue_zrl) begin
            lk_bits  = BITS_W'(lookup_code_i);
            lk_width = OW_W'(lookup_width_i);
        end else begin
            lk_bits  = (BITS_W'(lookup_code_i) << pend_size_q) | BITS_W'(pend_amp_q);
            lk_width = OW_W'(lookup_width_i) + OW_W'(pend_size_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        req_d   = 1'b0;
        v_d     = 1'b0;
        case (state_q)
            S_IN:     if (in_go)          state_d = S_LOOKUP;
            S_LOOKUP: if (lookup_valid_i) state_d = S_OUT;
            S_OUT:    if (yumi_i)         state_d = pend_sent_q ? S_IN : S_LOOKUP;
            default:                      state_d = S_IN;
        endcase
        if (img_start_i) state_d = S_IN;
        ready_d = (state_d == S_IN);
        req_d   = (state_d == S_LOOKUP);
        v_d     = (state_d == S_OUT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inport_ready_o <= 1'b0;
            lookup_req_o   <= 1'b0;
            v_o            <= 1'b0;
        end else begin
            inport_ready_o <= ready_d;
            lookup_req_o   <= req_d;
            v_o            <= v_d;
        end
    end

    // Block datapath: position/run tracking, predictors, pending symbol and output field
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coef_cnt_q      <= '0;
            run_q           <= '0;
            zrl_q           <= '0;
            cx_q            <= 1'b0;
            pend_sym_q      <= '0;
            pend_size_q     <= '0;
            pend_amp_q      <= '0;
            pend_last_q     <= 1'b0;
            pend_sent_q     <= 1'b0;
            lookup_table_o  <= '0;
            lookup_symbol_o <= '0;
            outport_bits_o  <= '0;
            outport_width_o <= '0;
            outport_last_o  <= 1'b0;
            for (int i = 0; i < 4; i++) prev_dc_q[i] <= '0;
`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
            error_o         <= 1'b0;
`endif
        end else if (img_start_i) begin
            coef_cnt_q  <= '0;
            run_q       <= '0;
            zrl_q       <= '0;
            pend_sent_q <= 1'b0;
            for (int i = 0; i < 4; i++) prev_dc_q[i] <= '0;
`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
            error_o     <= 1'b0;
`endif
        end else begin
            if (restart_i) begin
                for (int i = 0; i < 4; i++) prev_dc_q[i] <= '0;
            end
            if (xfer) begin
                coef_cnt_q <= coef_cnt_q + IDX_W'(1);
                run_q      <= (!is_dc && coef_zero && !is_end) ? run_q + IDX_W'(1) : '0;
                if (is_dc) begin
                    cx_q                      <= (inport_type_i != 2'd0);
                    prev_dc_q[inport_type_i]  <= inport_data_i;
                end
`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
                if (inport_idx_i != coef_cnt_q) error_o <= 1'b1;
`endif
            end
            if (in_go) begin
                zrl_q           <= in_zrl;
                pend_sym_q      <= in_sym;
                pend_size_q     <= coef_size;
                pend_amp_q      <= coef_amp;
                pend_last_q     <= is_end;
                pend_sent_q     <= 1'b0;
                lookup_table_o  <= {is_dc ? (inport_type_i != 2'd0) : cx_q, ~is_dc};
                lookup_symbol_o <= (in_zrl != 2'd0) ? 8'hF0 : in_sym;
            end
            if (state_q == S_LOOKUP && lookup_valid_i) begin
                outport_bits_o  <= lk_bits;
                outport_width_o <= lk_width;
                outport_last_o  <= ~issue_zrl & pend_last_q;
                if (issue_zrl) zrl_q       <= zrl_q - 2'd1;
                else           pend_sent_q <= 1'b1;
            end
            if (state_q == S_OUT && yumi_i && !pend_sent_q) begin
                lookup_symbol_o <= issue_zrl ? 8'hF0 : pend_sym_q;
            end
        end
    end

`ifndef JPEG_MCU_ENC_IDX_CHECK_EN
    // Position comes from the internal counter only
    logic idx_unused;
    assign idx_unused = ^inport_idx_i;
`endif

endmodule

// File: tb/tb_jpeg_mcu_enc.sv
// Directed bench for jpeg_mcu_enc: fixed Huffman table responder, auto-consuming sink, field scoreboard.
module tb_jpeg_mcu_enc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        img_start_i, restart_i, inport_v_i, inport_ready_o;
    logic [15:0] inport_data_i;
    logic [5:0]  inport_idx_i;
    logic [1:0]  inport_type_i;
    logic        lookup_req_o;
    logic [1:0]  lookup_table_o;
    logic [7:0]  lookup_symbol_o;
    logic        lookup_valid_i;
    logic [15:0] lookup_code_i;
    logic [4:0]  lookup_width_i;
    logic        v_o, yumi_i;
    logic [31:0] outport_bits_o;
    logic [5:0]  outport_width_o;
    logic        outport_last_o;
`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
    logic        error_o;
`endif

    always #5 clk_i = ~clk_i;

    jpeg_mcu_enc dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .img_start_i    (img_start_i),
        .restart_i      (restart_i),
        .inport_v_i     (inport_v_i),
        .inport_ready_o (inport_ready_o),
        .inport_data_i  (inport_data_i),
        .inport_idx_i   (inport_idx_i),
        .inport_type_i  (inport_type_i),
        .lookup_req_o   (lookup_req_o),
        .lookup_table_o (lookup_table_o),
        .lookup_symbol_o(lookup_symbol_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_code_i  (lookup_code_i),
        .lookup_width_i (lookup_width_i),
        .v_o            (v_o),
        .yumi_i         (yumi_i),
        .outport_bits_o (outport_bits_o),
        .outport_width_o(outport_width_o),
        .outport_last_o (outport_last_o)
`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
        ,
        .error_o        (error_o)
`endif
    );

    int          n_err = 0;
    int          n_chk = 0;
    bit          auto_yumi = 1'b1;
    int          lk_delay = 0;
    int          lk_wait = 0;
    logic [38:0] fq[$];
    logic [15:0] blk [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Test Huffman table: {width, code} per {table, symbol}
    function automatic logic [20:0] lut(input logic [1:0] t, input logic [7:0] s);
        case ({t, s})
            10'h000: return {5'd2,  16'h0000};
            10'h003: return {5'd3,  16'h0004};
            10'h002: return {5'd3,  16'h0003};
            10'h100: return {5'd4,  16'h000A};
            10'h1F0: return {5'd11, 16'h07F9};
            10'h143: return {5'd6,  16'h003B};
            10'h1E1: return {5'd16, 16'hFFF5};
            10'h201: return {5'd2,  16'h0001};
            10'h20B: return {5'd3,  16'h0006};
            10'h300: return {5'd2,  16'h0000};
            10'h301: return {5'd2,  16'h0001};
            default: return {5'd16, 16'hDEAD};
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (lookup_req_o && !lookup_valid_i) begin
            if (lk_wait >= lk_delay) begin
                lookup_valid_i = 1'b1;
                {lookup_width_i, lookup_code_i} = lut(lookup_table_o, lookup_symbol_o);
                lk_wait = 0;
            end else begin
                lk_wait++;
            end
        end else begin
            lookup_valid_i = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (v_o && auto_yumi && !yumi_i) begin
            fq.push_back({outport_last_o, outport_width_o, outport_bits_o});
            yumi_i = 1'b1;
        end else begin
            yumi_i = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!inport_ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (!inport_ready_o) check("ready_timeout", 32'(inport_ready_o), 32'd1);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 16'h0000;
    endtask

    task automatic send_block(input logic [1:0] typ, input logic [7:0] dc_sym, input int bad_at);
        for (int i = 0; i < 64; i++) begin
            wait_ready();
            inport_v_i    = 1'b1;
            inport_data_i = blk[i];
            inport_idx_i  = (i == bad_at) ? 6'd5 : 6'(i);
            inport_type_i = typ;
            @(negedge clk_i);
            inport_v_i = 1'b0;
            if (i == 0) begin
                check("dc_req",   32'(lookup_req_o),    32'd1);
                check("dc_ready", 32'(inport_ready_o),  32'd0);
                check("dc_table", 32'(lookup_table_o),  32'({typ != 2'd0, 1'b0}));
                check("dc_sym",   32'(lookup_symbol_o), 32'(dc_sym));
            end
        end
    endtask

    task automatic exp_field(input string tag, input logic [31:0] bits, input logic [5:0] width,
                             input logic last);
        int          n = 0;
        logic [38:0] f;
        while (fq.size() == 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (fq.size() == 0) begin
            check({tag, ".missing"}, 32'(fq.size()), 32'd1);
        end else begin
            f = fq.pop_front();
            check({tag, ".bits"},  f[31:0],       bits);
            check({tag, ".width"}, 32'(f[37:32]), 32'(width));
            check({tag, ".last"},  32'(f[38]),    32'(last));
        end
    endtask

    task automatic pulse(input bit is_img);
        if (is_img) img_start_i = 1'b1;
        else        restart_i   = 1'b1;
        @(negedge clk_i);
        img_start_i = 1'b0;
        restart_i   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; img_start_i = 1'b0; restart_i = 1'b0; inport_v_i = 1'b0;
        inport_data_i = '0; inport_idx_i = '0; inport_type_i = '0;
        lookup_valid_i = 1'b0; lookup_code_i = '0; lookup_width_i = '0; yumi_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", 32'(inport_ready_o),  32'd0);
        check("rst_req",   32'(lookup_req_o),    32'd0);
        check("rst_v",     32'(v_o),             32'd0);
        check("rst_bits",  outport_bits_o,       32'd0);
        check("rst_width", 32'(outport_width_o), 32'd0);
        check("rst_last",  32'(outport_last_o),  32'd0);
`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
        check("rst_error", 32'(error_o), 32'd0);
`endif
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_rst", 32'(inport_ready_o), 32'd1);

        // Y DC=+5 -> diff 5, all-zero AC -> EOB
        clear_blk(); blk[0] = 16'd5;
        send_block(2'd0, 8'h03, -1);
        exp_field("A_dc",  32'h25, 6'd6, 1'b0);
        exp_field("A_eob", 32'h0A, 6'd4, 1'b1);

        // Y DC=3 -> diff -2
        clear_blk(); blk[0] = 16'd3;
        send_block(2'd0, 8'h02, -1);
        exp_field("B_dc",  32'h0D, 6'd5, 1'b0);
        exp_field("B_eob", 32'h0A, 6'd4, 1'b1);

        // Cb DC=-1 against its own predictor
        clear_blk(); blk[0] = 16'hFFFF;
        send_block(2'd1, 8'h01, -1);
        exp_field("C_dc",  32'h2, 6'd3, 1'b0);
        exp_field("C_eob", 32'h0, 6'd2, 1'b1);

        // Run of 20 zeros then 7: one ZRL, then 0x43; slow lookups
        clear_blk(); blk[0] = 16'd3; blk[21] = 16'd7;
        lk_delay = 2;
        send_block(2'd0, 8'h00, -1);
        exp_field("D_dc",  32'h0,   6'd2,  1'b0);
        exp_field("D_zrl", 32'h7F9, 6'd11, 1'b0);
        exp_field("D_ac",  32'h1DF, 6'd9,  1'b0);
        exp_field("D_eob", 32'h0A,  6'd4,  1'b1);
        lk_delay = 0;

        // Last coefficient -1 after 62 zeros: three ZRLs, 0xE1 is final, no EOB
        clear_blk(); blk[0] = 16'd3; blk[63] = 16'hFFFF;
        send_block(2'd0, 8'h00, -1);
        exp_field("E_dc",   32'h0,     6'd2,  1'b0);
        exp_field("E_zrl0", 32'h7F9,   6'd11, 1'b0);
        exp_field("E_zrl1", 32'h7F9,   6'd11, 1'b0);
        exp_field("E_zrl2", 32'h7F9,   6'd11, 1'b0);
        exp_field("E_ac",   32'h1FFEA, 6'd17, 1'b1);
        repeat (6) @(negedge clk_i);
        check("E_no_eob", 32'(fq.size()), 32'd0);

        // Backpressure on Y DC=7 (diff 4), then abandon the block
        auto_yumi = 1'b0;
        wait_ready();
        inport_v_i = 1'b1; inport_data_i = 16'd7; inport_idx_i = 6'd0; inport_type_i = 2'd0;
        @(negedge clk_i);
        inport_v_i = 1'b0;
        for (int n = 0; n < 50 && !v_o; n++) @(negedge clk_i);
        for (int k = 0; k < 5; k++) begin
            check("bp_v",     32'(v_o),             32'd1);
            check("bp_bits",  outport_bits_o,       32'h24);
            check("bp_width", 32'(outport_width_o), 32'd6);
            check("bp_ready", 32'(inport_ready_o),  32'd0);
            @(negedge clk_i);
        end
        pulse(1'b1);
        check("img_v",     32'(v_o),            32'd0);
        check("img_req",   32'(lookup_req_o),   32'd0);
        check("img_ready", 32'(inport_ready_o), 32'd1);
        auto_yumi = 1'b1;
        repeat (2) @(negedge clk_i);
        check("img_dropped", 32'(fq.size()), 32'd0);

        // Predictors cleared: DC=4 -> diff 4
        clear_blk(); blk[0] = 16'd4;
        send_block(2'd0, 8'h03, -1);
        exp_field("G_dc",  32'h24, 6'd6, 1'b0);
        exp_field("G_eob", 32'h0A, 6'd4, 1'b1);

        // Cr DC=-1024 (size 11), adjacent AC=1
        clear_blk(); blk[0] = 16'hFC00; blk[1] = 16'd1;
        send_block(2'd2, 8'h0B, -1);
        exp_field("H_dc",  32'h33FF, 6'd14, 1'b0);
        exp_field("H_ac",  32'h3,    6'd3,  1'b0);
        exp_field("H_eob", 32'h0,    6'd2,  1'b1);

        // Restart clears the Y predictor (was 4)
        pulse(1'b0);
        clear_blk(); blk[0] = 16'd4;
        send_block(2'd0, 8'h03, -1);
        exp_field("I_dc",  32'h24, 6'd6, 1'b0);
        exp_field("I_eob", 32'h0A, 6'd4, 1'b1);

`ifdef JPEG_MCU_ENC_IDX_CHECK_EN
        clear_blk(); blk[0] = 16'd4;
        send_block(2'd0, 8'h00, 3);
        exp_field("J_dc",  32'h0,  6'd2, 1'b0);
        exp_field("J_eob", 32'h0A, 6'd4, 1'b1);
        check("err_set", 32'(error_o), 32'd1);
        send_block(2'd0, 8'h00, -1);
        exp_field("K_dc",  32'h0,  6'd2, 1'b0);
        exp_field("K_eob", 32'h0A, 6'd4, 1'b1);
        check("err_sticky", 32'(error_o), 32'd1);
        pulse(1'b1);
        check("err_clr", 32'(error_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
